data_path: RTL and testbench

- Datapath of a multicycle accumulator-style processor.
- Holds the PC, an internal byte memory, a two-byte instruction register (left/right halves), an operand register, a 4-entry register file, the ALU, a result register and C/Z/N flags.
- Every register and mux is driven by the external control unit; the opcode field and flags go back to it on toCU.

---
 rtl/data_path.sv | 138 +++++++++++++
 tb/tb_data_path.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/data_path.sv
// Datapath of a multicycle accumulator-style processor: PC, byte memory, IR halves,
// operand/data registers, 4-entry register file, ALU, result register and flags.
module data_path #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pcEn,
  input  logic       selAddress,
  input  logic       mr,
  input  logic       mw,
  input  logic       wordRegEn,
  input  logic       LSEn,
  input  logic       RSEn,
  input  logic       DIEn,
  input  logic [1:0] selData,
  input  logic [1:0] selAddressAC,
  input  logic       selALUsrc,
  input  logic       enb,
  input  logic       dataRegEn,
  input  logic       resultRegEn,
  input  logic       CEn,
  input  logic       ZEn,
  input  logic       NEn,
  input  logic [2:0] operation,
  output logic [6:0] toCU
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned SW    = DW + 1;
  localparam int unsigned RF_N  = 4;

  logic [AW-1:0] pc;
  logic [DW-1:0] ls;
  logic [DW-1:0] rs;
  logic [DW-1:0] di;
  logic [DW-1:0] word_reg;
  logic [DW-1:0] data_reg;
  logic [DW-1:0] result_reg;
  logic [DW-1:0] rf [RF_N];
  logic          c_flag;
  logic          z_flag;
  logic          n_flag;

  logic [DW-1:0] mem [DEPTH];

  logic [AW-1:0] addr;
  logic [DW-1:0] mem_out;
  logic [DW-1:0] rf_rd;
  logic [DW-1:0] rf_wd;
  logic [DW-1:0] alu_b;
  logic [DW-1:0] alu_res;
  logic          alu_carry;
  logic [SW-1:0] sum;

  // Operand address is the low nibble of LS concatenated with RS.
  always_comb begin
    addr    = selAddress ? AW'({ls[3:0], rs}) : pc;
    mem_out = mr ? mem[addr] : '0;
  end

  // Main memory is not reset; contents are preloaded by the environment.
  always_ff @(posedge clk) begin
    if (mw) begin
      mem[addr] <= data_reg;
    end
  end

  always_comb begin
    rf_rd = rf[selAddressAC];
    unique case (selData)
      2'b00:   rf_wd = result_reg;
      2'b01:   rf_wd = di;
      2'b10:   rf_wd = rs;
      default: rf_wd = '0;
    endcase
  end

  // ALU: A is always the data register, B selects DI or the word register.
  always_comb begin
    alu_b     = selALUsrc ? word_reg : di;
    alu_res   = '0;
    alu_carry = 1'b0;
    sum       = '0;
    unique case (operation)
      3'b000: begin
        sum       = {1'b0, data_reg} + {1'b0, alu_b};
        alu_res   = sum[DW-1:0];
        alu_carry = sum[DW];
      end
      3'b001: begin
        sum       = {1'b0, data_reg} + {1'b0, ~alu_b} + SW'(1);
        alu_res   = sum[DW-1:0];
        alu_carry = sum[DW];
      end
      3'b010:  alu_res = data_reg & alu_b;
      3'b011:  alu_res = data_reg | alu_b;
      3'b100:  alu_res = data_reg ^ alu_b;
      3'b101:  alu_res = ~data_reg;
      3'b110:  alu_res = alu_b;
      default: alu_res = data_reg;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc         <= '0;
      ls         <= '0;
      rs         <= '0;
      di         <= '0;
      word_reg   <= '0;
      data_reg   <= '0;
      result_reg <= '0;
      c_flag     <= 1'b0;
      z_flag     <= 1'b0;
      n_flag     <= 1'b0;
      for (int i = 0; i < RF_N; i++) begin
        rf[i] <= '0;
      end
    end else begin
      if (pcEn)        pc         <= pc + AW'(1);
      if (LSEn)        ls         <= mem_out;
      if (RSEn)        rs         <= mem_out;
      if (DIEn)        di         <= mem_out;
      if (wordRegEn)   word_reg   <= rf_rd;
      if (dataRegEn)   data_reg   <= rf_rd;
      if (resultRegEn) result_reg <= alu_res;
      if (CEn)         c_flag     <= alu_carry;
      if (ZEn)         z_flag     <= (alu_res == '0);
      if (NEn)         n_flag     <= alu_res[DW-1];
      if (enb)         rf[selAddressAC] <= rf_wd;
    end
  end

  assign toCU = {ls[DW-1:DW-4], c_flag, z_flag, n_flag};

endmodule

// File: tb/tb_data_path.sv
// Directed bench for data_path with a cycle-level behavioural model and per-cycle compare.
module tb_data_path;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pcEn, selAddress, mr, mw, wordRegEn, LSEn, RSEn, DIEn;
  logic [1:0] selData, selAddressAC;
  logic       selALUsrc, enb, dataRegEn, resultRegEn, CEn, ZEn, NEn;
  logic [2:0] operation;
  logic [6:0] toCU;

  int errors = 0;
  int checks = 0;

  int m_pc, m_ls, m_rs, m_di, m_word, m_data, m_res, m_c, m_z, m_n;
  int m_rf [4];
  int m_mem [4096];

  data_path #(.DW(8), .AW(12)) dut (
    .clk(clk), .reset(reset), .pcEn(pcEn), .selAddress(selAddress), .mr(mr), .mw(mw),
    .wordRegEn(wordRegEn), .LSEn(LSEn), .RSEn(RSEn), .DIEn(DIEn), .selData(selData),
    .selAddressAC(selAddressAC), .selALUsrc(selALUsrc), .enb(enb), .dataRegEn(dataRegEn),
    .resultRegEn(resultRegEn), .CEn(CEn), .ZEn(ZEn), .NEn(NEn), .operation(operation),
    .toCU(toCU)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: what each architectural register holds after the edge.
  always @(posedge clk) begin
    int a, b, r, addr, mo, rd, wd, cy;
    if (!reset) begin
      m_pc <= 0; m_ls <= 0; m_rs <= 0; m_di <= 0; m_word <= 0; m_data <= 0;
      m_res <= 0; m_c <= 0; m_z <= 0; m_n <= 0;
      for (int i = 0; i < 4; i++) m_rf[i] <= 0;
    end else begin
      addr = selAddress ? (m_ls % 16) * 256 + m_rs : m_pc;
      mo   = mr ? m_mem[addr] : 0;
      a    = m_data;
      b    = selALUsrc ? m_word : m_di;
      cy   = 0;
      case (operation)
        3'd0: begin r = (a + b) % 256; cy = (a + b > 255) ? 1 : 0; end
        3'd1: begin r = (a - b + 256) % 256; cy = (a >= b) ? 1 : 0; end
        3'd2: r = a & b;
        3'd3: r = a | b;
        3'd4: r = a ^ b;
        3'd5: r = 255 - a;
        3'd6: r = b;
        default: r = a;
      endcase
      rd = m_rf[selAddressAC];
      case (selData)
        2'd0: wd = m_res;
        2'd1: wd = m_di;
        2'd2: wd = m_rs;
        default: wd = 0;
      endcase
      if (pcEn)        m_pc   <= (m_pc + 1) % 4096;
      if (LSEn)        m_ls   <= mo;
      if (RSEn)        m_rs   <= mo;
      if (DIEn)        m_di   <= mo;
      if (wordRegEn)   m_word <= rd;
      if (dataRegEn)   m_data <= rd;
      if (resultRegEn) m_res  <= r;
      if (CEn)         m_c    <= cy;
      if (ZEn)         m_z    <= (r == 0) ? 1 : 0;
      if (NEn)         m_n    <= (r >= 128) ? 1 : 0;
      if (enb)         m_rf[selAddressAC] <= wd;
    end
    if (mw) m_mem[selAddress ? (m_ls % 16) * 256 + m_rs : m_pc] <= m_data;
  end

  // Compare every architectural register and toCU against the model.
  always @(negedge clk) begin
    chk("pc", 32'(dut.pc), 32'(m_pc));
    chk("ls", 32'(dut.ls), 32'(m_ls));
    chk("rs", 32'(dut.rs), 32'(m_rs));
    chk("di", 32'(dut.di), 32'(m_di));
    chk("word_reg", 32'(dut.word_reg), 32'(m_word));
    chk("data_reg", 32'(dut.data_reg), 32'(m_data));
    chk("result_reg", 32'(dut.result_reg), 32'(m_res));
    for (int i = 0; i < 4; i++) chk($sformatf("rf%0d", i), 32'(dut.rf[i]), 32'(m_rf[i]));
    chk("toCU", 32'(toCU), 32'((m_ls / 16) * 8 + m_c * 4 + m_z * 2 + m_n));
  end

  task automatic idle();
    pcEn = 0; selAddress = 0; mr = 0; mw = 0; wordRegEn = 0; LSEn = 0; RSEn = 0;
    DIEn = 0; selData = 0; selAddressAC = 0; selALUsrc = 0; enb = 0; dataRegEn = 0;
    resultRegEn = 0; CEn = 0; ZEn = 0; NEn = 0; operation = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    idle();
  endtask

  task automatic load(input int a, input logic [7:0] v);
    dut.mem[a] = v;
    m_mem[a] = int'(v);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      dut.mem[i] = 8'h00;
      m_mem[i] = 0;
    end
    pcEn = 1; selAddress = 1; mr = 1; mw = 1; wordRegEn = 1; LSEn = 1; RSEn = 1;
    DIEn = 1; selData = 3; selAddressAC = 3; selALUsrc = 1; enb = 1; dataRegEn = 1;
    resultRegEn = 1; CEn = 1; ZEn = 1; NEn = 1; operation = 3'd5;
    repeat (3) @(negedge clk);
    chk("reset pc", 32'(dut.pc), 32'h0);
    chk("reset toCU", 32'(toCU), 32'h0);
    chk("reset result", 32'(dut.result_reg), 32'h0);

    reset = 1;
    idle();
    repeat (3) tick();
    chk("pc hold", 32'(dut.pc), 32'h0);
    pcEn = 1; tick(); pcEn = 1; tick(); pcEn = 1; tick();
    chk("pc count", 32'(dut.pc), 32'h3);
    for (int i = 0; i < 4093; i++) begin pcEn = 1; tick(); end
    chk("pc wrap", 32'(dut.pc), 32'h0);

    load(0, 8'h21); load(1, 8'h05); load(2, 8'hF0); load(3, 8'h20);
    load(4, 8'h01); load(5, 8'h5A); load(12'h105, 8'h0F);

    mr = 1; pcEn = 1; LSEn = 1; tick();
    mr = 1; pcEn = 1; RSEn = 1; tick();
    chk("fetch ls", 32'(dut.ls), 32'h21);
    chk("fetch rs", 32'(dut.rs), 32'h05);
    chk("fetch pc", 32'(dut.pc), 32'h2);
    chk("fetch opcode", 32'(toCU[6:3]), 32'h2);

    selAddress = 1; mr = 1; DIEn = 1; tick();
    chk("operand di", 32'(dut.di), 32'h0F);
    selData = 1; selAddressAC = 2; enb = 1; tick();
    chk("rf2 load", 32'(dut.rf[2]), 32'h0F);

    mr = 1; pcEn = 1; DIEn = 1; tick();
    selData = 1; selAddressAC = 1; enb = 1; tick();
    selAddressAC = 1; dataRegEn = 1; tick();
    mr = 1; pcEn = 1; DIEn = 1; tick();
    operation = 3'd0; resultRegEn = 1; CEn = 1; ZEn = 1; NEn = 1; tick();
    chk("add result", 32'(dut.result_reg), 32'h10);
    chk("add toCU", 32'(toCU), 32'h14);

    selData = 2; selAddressAC = 0; enb = 1; tick();
    selAddressAC = 0; dataRegEn = 1; wordRegEn = 1; tick();
    operation = 3'd1; selALUsrc = 1; resultRegEn = 1; CEn = 1; ZEn = 1; NEn = 1; tick();
    chk("sub eq result", 32'(dut.result_reg), 32'h00);
    chk("sub eq flags", 32'(toCU[2:0]), 32'b110);

    selData = 3; selAddressAC = 3; enb = 1; tick();
    selAddressAC = 3; dataRegEn = 1; tick();
    mr = 1; pcEn = 1; DIEn = 1; tick();
    selData = 1; selAddressAC = 2; enb = 1; wordRegEn = 1; tick();
    chk("read-during-write old", 32'(dut.word_reg), 32'h0F);
    selAddressAC = 2; wordRegEn = 1; tick();
    operation = 3'd1; selALUsrc = 1; resultRegEn = 1; CEn = 1; ZEn = 1; NEn = 1; tick();
    chk("sub borrow result", 32'(dut.result_reg), 32'hFF);
    chk("sub borrow flags", 32'(toCU[2:0]), 32'b001);

    mr = 1; pcEn = 1; DIEn = 1; tick();
    selData = 1; selAddressAC = 3; enb = 1; tick();
    selAddressAC = 3; dataRegEn = 1; tick();
    selAddress = 1; mw = 1; tick();
    chk("store mem", 32'(dut.mem[12'h105]), 32'h5A);
    selData = 2; selAddressAC = 1; enb = 1; tick();
    chk("immediate rf1", 32'(dut.rf[1]), 32'h05);
    operation = 3'd5; resultRegEn = 1; tick();
    chk("not result", 32'(dut.result_reg), 32'hA5);
    chk("flags held", 32'(toCU[2:0]), 32'b001);

    DIEn = 1; tick();
    chk("mr low di", 32'(dut.di), 32'h00);
    selAddress = 1; mr = 1; DIEn = 1; tick();
    chk("reload stored", 32'(dut.di), 32'h5A);

    for (int op = 0; op < 8; op++) begin
      for (int s = 0; s < 2; s++) begin
        operation = 3'(op); selALUsrc = s[0];
        resultRegEn = 1; CEn = 1; ZEn = 1; NEn = 1; tick();
      end
    end

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
